cp0_reg: RTL and testbench
==========================

CP0_REG -- requirements
Module: cp0_reg

Interface
REQ-001 SHALL have these ports (direction, width, meaning):
- cpu_clk_50M  in  1: single clock, all state on rising edge.
- cpu_rst  in  1: asynchronous, active-high reset.
- cp0_we  in  1: MTC0 write enable, from the MEM stage.
- cp0_waddr  in  5: CP0 register number to write.
- cp0_wdata  in  32: write data.
- cp0_raddr  in  5: MFC0 read register number.
- mem_valid  in  1: MEM slot holds a real instruction, not a bubble.
- mem_pc  in  32: PC of the MEM-stage instruction.
- mem_in_delay  in  1: that instruction sits in a delay slot.
- mem_exccode  in  5: exception code carried down the pipe.
- mem_badvaddr  in  32: faulting address for ADEL/ADES.
- int_i  in  6: external hardware interrupts.
- cp0_rdata  out  32: MFC0 read data.
- flush  out  1: flush all pipeline registers.
- cp0_excaddr  out  32: redirect PC.
- timer_int_o  out  1: timer interrupt pending.
REQ-002 SHALL use these parameters/constants (name, default, meaning):
- EXC_ADDR, 32'h0000_0100: exception handler entry.
- EXC_NONE, 5'h10: no exception.
- EXC_ERET, 5'h11: ERET.
- EXC_INT, 5'h00: interrupt.
- EXC_ADEL, 5'h04 and EXC_ADES, 5'h05: address errors.

Function
REQ-003 SHALL implement BadVAddr(8), Count(9), Compare(11), Status(12), Cause(13) and EPC(14); any other register number SHALL read as zero, and writes to it SHALL be ignored.
REQ-004 Writable bits SHALL be: Status IM[15:8], EXL[1], IE[0]; Cause IP[1:0]; Count, Compare and EPC in full. All other bits are read-only.
REQ-005 Count SHALL increment by 1 every cycle and wrap from 32'hFFFF_FFFF to 0; an MTC0 to Count in the same cycle SHALL win over the increment.
REQ-006 timer_int_o SHALL set on the cycle after Count==Compare with Compare!=0, SHALL stay set until Compare is written, and an MTC0 to Compare SHALL clear it.
REQ-007 Cause.IP[7:2] SHALL be registered each cycle from {int_i[5] | timer_int_o, int_i[4:0]}.
REQ-008 An interrupt is pending when Status.IE=1, Status.EXL=0, (Status.IM & Cause.IP)!=0, mem_valid=1 and mem_exccode==EXC_NONE; in that case the effective exccode SHALL be EXC_INT, otherwise it SHALL be mem_exccode.
REQ-009 On any effective exccode other than EXC_NONE and EXC_ERET:
- flush=1 combinationally in the same cycle; cp0_excaddr=EXC_ADDR.
- Next edge: Cause.ExcCode <= code.
- If EXL was 0: EPC <= mem_in_delay ? mem_pc-4 : mem_pc; Cause.BD <= mem_in_delay; then EXL <= 1.
- If EXL was already 1: EPC and BD SHALL stay unchanged.
REQ-010 On ADEL or ADES, BadVAddr SHALL load mem_badvaddr.
REQ-011 On EXC_ERET: flush=1; cp0_excaddr=EPC, forwarded from cp0_wdata when the same cycle writes EPC; Status.EXL <= 0 at the next edge.
REQ-012 An exception or ERET SHALL suppress a simultaneous MTC0 in the same cycle.
REQ-013 cp0_rdata SHALL be combinational, and SHALL forward masked cp0_wdata when cp0_we=1 and cp0_waddr==cp0_raddr.
REQ-014 When there is no exception and no ERET: flush=0 and cp0_excaddr=0.

Reset
REQ-015 While cpu_rst=1, the registers SHALL reset to: Status=32'h1000_0000; Cause, EPC, BadVAddr, Count and Compare=0; timer_int_o=0.
REQ-016 A reset asserted mid-exception SHALL discard the pending update, and flush SHALL read 0 during reset.

Structure
REQ-017 Exception codes, register numbers, EXC_ADDR and the field bit positions SHALL live in the shared defines package.
REQ-018 Exception/interrupt priority resolution SHALL be one combinational sub-module, cp0_exc_arb; the register file stays in cp0_reg.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Reset: after release, read reg 12 -> 32'h1000_0000; read Count three cycles later -> 3.
- Compare: write Compare=20 with Count≈0 -> timer_int_o=1 at Count 21; write Compare again -> timer_int_o=0 next cycle.
- Delay-slot exception: mem_exccode=5'h0c, mem_pc=32'h8000_0104, mem_in_delay=1, EXL=0 -> flush=1, excaddr=32'h100; then EPC=32'h8000_0100, BD=1, EXL=1.
- Nested exception: same stimulus again with EXL=1 -> EPC unchanged; ExcCode updated.
- ERET with a same-cycle MTC0 EPC=32'h1234 -> excaddr=32'h1234 (ERET wins, write suppressed), EXL=0.
- Interrupt: IE=1, IM[2]=1, int_i[0]=1, mem_valid=1 -> ExcCode=0, flush=1.

Source files
------------

// File: rtl/cp0_reg_pkg.sv
// cp0_reg_pkg: shared CP0 register numbers, exception codes, field positions and helpers
package cp0_reg_pkg;
  localparam logic [31:0] EXC_ADDR = 32'h0000_0100;
  localparam logic [4:0] EXC_NONE = 5'h10;
  localparam logic [4:0] EXC_ERET = 5'h11;
  localparam logic [4:0] EXC_INT = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT = 5'd9;
  localparam logic [4:0] REG_COMPARE = 5'd11;
  localparam logic [4:0] REG_STATUS = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC = 5'd14;
  localparam int STATUS_IE = 0;
  localparam int STATUS_EXL = 1;
  localparam int IM_LO = 8;
  localparam int IM_HI = 15;
  localparam int CAUSE_BD = 31;
  localparam int IP_LO = 8;
  localparam int IP_HW_LO = 10;
  localparam int IP_HI = 15;
  localparam int EXCCODE_LO = 2;
  localparam int EXCCODE_HI = 6;
  localparam logic [31:0] STATUS_RST = 32'h1000_0000;
  localparam logic [31:0] STATUS_WMASK = 32'h0000_ff03;
  localparam logic [31:0] CAUSE_WMASK = 32'h0000_0300;
  typedef struct packed {
    logic [31:0] badvaddr;
    logic [31:0] count;
    logic [31:0] compare;
    logic [31:0] status;
    logic [31:0] cause;
    logic [31:0] epc;
  } cp0_regs_t;
  localparam cp0_regs_t CP0_RST = '{badvaddr: 32'h0, count: 32'h0, compare: 32'h0,
                                    status: STATUS_RST, cause: 32'h0, epc: 32'h0};
  function automatic logic [31:0] cp0_sel(input logic [4:0] a, input cp0_regs_t r);
    return a == REG_BADVADDR ? r.badvaddr :
           a == REG_COUNT    ? r.count :
           a == REG_COMPARE  ? r.compare :
           a == REG_STATUS   ? r.status :
           a == REG_CAUSE    ? r.cause :
           a == REG_EPC      ? r.epc : 32'h0;
  endfunction
  function automatic logic [31:0] cp0_wmask(input logic [4:0] a);
    return a == REG_COUNT || a == REG_COMPARE || a == REG_EPC ? 32'hffff_ffff :
           a == REG_STATUS ? STATUS_WMASK :
           a == REG_CAUSE  ? CAUSE_WMASK : 32'h0;
  endfunction
endpackage

// File: rtl/cp0_exc_arb.sv
// cp0_exc_arb: resolves the effective exception code between interrupts and pipe-carried exceptions
module cp0_exc_arb
  import cp0_reg_pkg::*;
(
  input  logic       ie,
  input  logic       exl,
  input  logic [7:0] im,
  input  logic [7:0] ip,
  input  logic       mem_valid,
  input  logic [4:0] mem_exccode,
  output logic [4:0] exccode,
  output logic       exc,
  output logic       eret
);
  always_comb begin
    exccode = ie && !exl && |(im & ip) && mem_valid && mem_exccode == EXC_NONE ? EXC_INT : mem_exccode;
    eret = exccode == EXC_ERET;
    exc = exccode != EXC_NONE && exccode != EXC_ERET;
  end
endmodule

// File: rtl/cp0_reg.sv
// cp0_reg: MIPS coprocessor 0 register file with timer, interrupt and exception entry/return
module cp0_reg
  import cp0_reg_pkg::*;
(
  input  logic        cpu_clk_50M,
  input  logic        cpu_rst,
  input  logic        cp0_we,
  input  logic [4:0]  cp0_waddr,
  input  logic [31:0] cp0_wdata,
  input  logic [4:0]  cp0_raddr,
  input  logic        mem_valid,
  input  logic [31:0] mem_pc,
  input  logic        mem_in_delay,
  input  logic [4:0]  mem_exccode,
  input  logic [31:0] mem_badvaddr,
  input  logic [5:0]  int_i,
  output logic [31:0] cp0_rdata,
  output logic        flush,
  output logic [31:0] cp0_excaddr,
  output logic        timer_int_o
);
  cp0_regs_t r;
  logic [4:0] exccode;
  logic exc, eret, wr;
  logic [31:0] wmask, wmerge, epc_fwd;
  cp0_exc_arb u_arb (
    .ie(r.status[STATUS_IE]),
    .exl(r.status[STATUS_EXL]),
    .im(r.status[IM_HI:IM_LO]),
    .ip(r.cause[IP_HI:IP_LO]),
    .mem_valid,
    .mem_exccode,
    .exccode,
    .exc,
    .eret
  );
  always_comb begin
    wr = cp0_we && !exc && !eret;
    wmask = cp0_wmask(cp0_waddr);
    wmerge = (cp0_sel(cp0_waddr, r) & ~wmask) | (cp0_wdata & wmask);
    cp0_rdata = cp0_we && cp0_waddr == cp0_raddr ? wmerge : cp0_sel(cp0_raddr, r);
    epc_fwd = cp0_we && cp0_waddr == REG_EPC ? cp0_wdata : r.epc;
    flush = !cpu_rst && (exc || eret);
    cp0_excaddr = exc ? EXC_ADDR : eret ? epc_fwd : 32'h0;
  end
  always_ff @(posedge cpu_clk_50M or posedge cpu_rst)
    if (cpu_rst) begin
      r <= CP0_RST;
      timer_int_o <= 1'b0;
    end else begin
      r.count <= wr && cp0_waddr == REG_COUNT ? cp0_wdata : r.count + 32'd1;
      if (wr && cp0_waddr == REG_COMPARE) r.compare <= cp0_wdata;
      if (wr && cp0_waddr == REG_STATUS) r.status <= wmerge;
      if (wr && cp0_waddr == REG_CAUSE) r.cause <= wmerge;
      if (wr && cp0_waddr == REG_EPC) r.epc <= wmerge;
      timer_int_o <= wr && cp0_waddr == REG_COMPARE ? 1'b0 :
                     r.count == r.compare && r.compare != 32'h0 ? 1'b1 : timer_int_o;
      r.cause[IP_HI:IP_HW_LO] <= {int_i[5] | timer_int_o, int_i[4:0]};
      if (exc) begin
        r.cause[EXCCODE_HI:EXCCODE_LO] <= exccode;
        if (!r.status[STATUS_EXL]) begin
          r.epc <= mem_in_delay ? mem_pc - 32'd4 : mem_pc;
          r.cause[CAUSE_BD] <= mem_in_delay;
          r.status[STATUS_EXL] <= 1'b1;
        end
        if (exccode == EXC_ADEL || exccode == EXC_ADES) r.badvaddr <= mem_badvaddr;
      end
      if (eret) r.status[STATUS_EXL] <= 1'b0;
    end
endmodule

// File: tb/tb_cp0_reg.sv
// tb_cp0_reg: randomized and directed checking of cp0_reg against a register-array model
module tb_cp0_reg;
  logic cpu_clk_50M = 1'b0;
  logic cpu_rst = 1'b1;
  logic cp0_we = 1'b0;
  logic [4:0] cp0_waddr = 5'd0;
  logic [31:0] cp0_wdata = 32'h0;
  logic [4:0] cp0_raddr = 5'd0;
  logic mem_valid = 1'b0;
  logic [31:0] mem_pc = 32'h0;
  logic mem_in_delay = 1'b0;
  logic [4:0] mem_exccode = 5'h10;
  logic [31:0] mem_badvaddr = 32'h0;
  logic [5:0] int_i = 6'h0;
  logic [31:0] cp0_rdata, cp0_excaddr;
  logic flush, timer_int_o;
  int checks = 0;
  int failures = 0;
  logic [31:0] m [0:31];
  logic mt;
  cp0_reg dut (
    .cpu_clk_50M(cpu_clk_50M),
    .cpu_rst(cpu_rst),
    .cp0_we(cp0_we),
    .cp0_waddr(cp0_waddr),
    .cp0_wdata(cp0_wdata),
    .cp0_raddr(cp0_raddr),
    .mem_valid(mem_valid),
    .mem_pc(mem_pc),
    .mem_in_delay(mem_in_delay),
    .mem_exccode(mem_exccode),
    .mem_badvaddr(mem_badvaddr),
    .int_i(int_i),
    .cp0_rdata(cp0_rdata),
    .flush(flush),
    .cp0_excaddr(cp0_excaddr),
    .timer_int_o(timer_int_o)
  );
  always #5 cpu_clk_50M = ~cpu_clk_50M;
  task automatic check(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", n, a, e);
    end
  endtask
  function automatic logic [31:0] wmask(input logic [4:0] a);
    case (a)
      5'd9, 5'd11, 5'd14: return 32'hffff_ffff;
      5'd12: return 32'h0000_ff03;
      5'd13: return 32'h0000_0300;
      default: return 32'h0;
    endcase
  endfunction
  function automatic logic [31:0] merged(input logic [4:0] a, input logic [31:0] d);
    return (m[a] & ~wmask(a)) | (d & wmask(a));
  endfunction
  function automatic logic [4:0] mcode();
    logic pend;
    pend = m[12][0] && !m[12][1] && (m[12][15:8] & m[13][15:8]) != 8'h0 && mem_valid && mem_exccode == 5'h10;
    return pend ? 5'h00 : mem_exccode;
  endfunction
  task automatic model_step();
    logic [4:0] c;
    logic ex, er, wr;
    logic [31:0] o [0:31];
    if (cpu_rst) begin
      foreach (m[i]) m[i] = 32'h0;
      m[12] = 32'h1000_0000;
      mt = 1'b0;
      return;
    end
    c = mcode();
    er = c == 5'h11;
    ex = c != 5'h10 && !er;
    wr = cp0_we && !ex && !er;
    o = m;
    m[9] = o[9] + 32'd1;
    if (wr) m[cp0_waddr] = merged(cp0_waddr, cp0_wdata);
    m[13][15:10] = {int_i[5] | mt, int_i[4:0]};
    mt = (wr && cp0_waddr == 5'd11) ? 1'b0 : (o[9] == o[11] && o[11] != 32'h0) ? 1'b1 : mt;
    if (ex) begin
      m[13][6:2] = c;
      if (!o[12][1]) begin
        m[14] = mem_in_delay ? mem_pc - 32'd4 : mem_pc;
        m[13][31] = mem_in_delay;
        m[12][1] = 1'b1;
      end
      if (c == 5'h04 || c == 5'h05) m[8] = mem_badvaddr;
    end
    if (er) m[12][1] = 1'b0;
  endtask
  always @(posedge cpu_clk_50M) model_step();
  always @(negedge cpu_clk_50M) begin : cmp
    logic [4:0] c;
    logic ex, er;
    if (cpu_rst) check("flush_rst", {31'h0, flush}, 32'h0);
    else begin
      c = mcode();
      er = c == 5'h11;
      ex = c != 5'h10 && !er;
      check("rdata", cp0_rdata, (cp0_we && cp0_waddr == cp0_raddr) ? merged(cp0_raddr, cp0_wdata) : m[cp0_raddr]);
      check("flush", {31'h0, flush}, {31'h0, ex | er});
      check("excaddr", cp0_excaddr, ex ? 32'h100 : er ? ((cp0_we && cp0_waddr == 5'd14) ? cp0_wdata : m[14]) : 32'h0);
      check("timer", {31'h0, timer_int_o}, {31'h0, mt});
    end
  end
  task automatic step();
    @(posedge cpu_clk_50M);
    #1;
  endtask
  task automatic idle();
    cp0_we = 1'b0;
    mem_valid = 1'b0;
    mem_exccode = 5'h10;
    mem_in_delay = 1'b0;
  endtask
  task automatic rd(input logic [4:0] a, input logic [31:0] e, input string n);
    cp0_raddr = a;
    #1;
    check(n, cp0_rdata, e);
  endtask
  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    cp0_we = 1'b1;
    cp0_waddr = a;
    cp0_wdata = d;
    step();
    cp0_we = 1'b0;
  endtask
  function automatic logic [4:0] pick();
    logic [4:0] t [0:5];
    t = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14};
    return $urandom_range(0, 3) == 0 ? 5'($urandom) : t[$urandom_range(0, 5)];
  endfunction
  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end
  initial begin
    int r;
    step();
    step();
    cpu_rst = 1'b0;
    rd(5'd12, 32'h1000_0000, "rst_status");
    rd(5'd13, 32'h0, "rst_cause");
    rd(5'd14, 32'h0, "rst_epc");
    rd(5'd9, 32'h0, "rst_count");
    check("rst_timer", {31'h0, timer_int_o}, 32'h0);
    step();
    step();
    step();
    rd(5'd9, 32'd3, "count_3");
    mtc0(5'd11, 32'd20);
    for (int i = 0; i < 100 && !timer_int_o; i++) step();
    check("timer_set", {31'h0, timer_int_o}, 32'h1);
    rd(5'd9, 32'd21, "timer_count");
    step();
    step();
    check("timer_hold", {31'h0, timer_int_o}, 32'h1);
    mtc0(5'd11, 32'd100000);
    check("timer_clr", {31'h0, timer_int_o}, 32'h0);
    mtc0(5'd9, 32'hffff_ffff);
    rd(5'd9, 32'hffff_ffff, "count_max");
    step();
    rd(5'd9, 32'h0, "count_wrap");
    cp0_we = 1'b1;
    cp0_waddr = 5'd3;
    cp0_wdata = 32'hffff_ffff;
    rd(5'd3, 32'h0, "unimpl_fwd");
    step();
    cp0_we = 1'b0;
    rd(5'd3, 32'h0, "unimpl_read");
    cp0_we = 1'b1;
    cp0_waddr = 5'd12;
    cp0_wdata = 32'hffff_ffff;
    rd(5'd12, 32'h1000_ff03, "fwd_status");
    cp0_we = 1'b0;
    step();
    mem_valid = 1'b1;
    mem_exccode = 5'h0c;
    mem_pc = 32'h8000_0104;
    mem_in_delay = 1'b1;
    #1;
    check("ds_flush", {31'h0, flush}, 32'h1);
    check("ds_excaddr", cp0_excaddr, 32'h100);
    step();
    idle();
    rd(5'd14, 32'h8000_0100, "ds_epc");
    rd(5'd13, 32'h8000_0030, "ds_cause");
    rd(5'd12, 32'h1000_0002, "ds_status");
    check("model_epc", m[14], 32'h8000_0100);
    mem_valid = 1'b1;
    mem_exccode = 5'h04;
    mem_pc = 32'h8000_0200;
    mem_badvaddr = 32'hdead_beef;
    #1;
    check("nest_flush", {31'h0, flush}, 32'h1);
    check("nest_excaddr", cp0_excaddr, 32'h100);
    step();
    idle();
    rd(5'd14, 32'h8000_0100, "nest_epc");
    rd(5'd13, 32'h8000_0010, "nest_cause");
    rd(5'd8, 32'hdead_beef, "nest_badvaddr");
    check("model_cause", m[13], 32'h8000_0010);
    mem_valid = 1'b1;
    mem_exccode = 5'h11;
    cp0_we = 1'b1;
    cp0_waddr = 5'd14;
    cp0_wdata = 32'h1234;
    #1;
    check("eret_excaddr", cp0_excaddr, 32'h1234);
    check("eret_flush", {31'h0, flush}, 32'h1);
    step();
    idle();
    rd(5'd14, 32'h8000_0100, "eret_epc_kept");
    rd(5'd12, 32'h1000_0000, "eret_status");
    mtc0(5'd12, 32'h0000_0401);
    int_i = 6'h01;
    step();
    mem_valid = 1'b1;
    mem_pc = 32'h8000_0300;
    #1;
    check("int_flush", {31'h0, flush}, 32'h1);
    check("int_excaddr", cp0_excaddr, 32'h100);
    step();
    idle();
    int_i = 6'h00;
    rd(5'd13, 32'h0000_0400, "int_cause");
    rd(5'd14, 32'h8000_0300, "int_epc");
    rd(5'd12, 32'h1000_0403, "int_status");
    mem_valid = 1'b1;
    mem_exccode = 5'h0c;
    mem_pc = 32'h8000_0500;
    cpu_rst = 1'b1;
    #1;
    check("rst_mid_flush", {31'h0, flush}, 32'h0);
    step();
    cpu_rst = 1'b0;
    idle();
    rd(5'd14, 32'h0, "rst_mid_epc");
    rd(5'd12, 32'h1000_0000, "rst_mid_status");
    for (int i = 0; i < 3000; i++) begin
      cpu_rst = $urandom_range(0, 199) == 0;
      cp0_we = $urandom_range(0, 3) == 0;
      cp0_waddr = pick();
      cp0_raddr = $urandom_range(0, 3) == 0 ? cp0_waddr : pick();
      cp0_wdata = $urandom;
      if (cp0_waddr == 5'd11 && $urandom_range(0, 1) == 1) cp0_wdata = m[9] + 32'($urandom_range(1, 8));
      mem_valid = $urandom_range(0, 1) == 1;
      r = $urandom_range(0, 19);
      mem_exccode = r < 14 ? 5'h10 : r < 16 ? 5'h11 : r == 16 ? 5'h04 : r == 17 ? 5'h05 : 5'($urandom);
      mem_pc = $urandom & 32'hffff_fffc;
      mem_in_delay = $urandom_range(0, 1) == 1;
      mem_badvaddr = $urandom;
      int_i = $urandom_range(0, 7) == 0 ? 6'($urandom) : 6'h0;
      step();
    end
    cpu_rst = 1'b0;
    idle();
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
